// File: rtl/fraction_division_if.sv
// fraction_division_if: St/Done handshake and operand/result bus of the fraction divider
interface fraction_division_if;
  logic       St;
  logic [6:0] Dividend;
  logic [3:0] Divisor;
  logic [3:0] Quotient;
  logic [3:0] Remainder;
  logic       V;
  logic       Done;
  modport master(output St, Dividend, Divisor, input Quotient, Remainder, V, Done);
  modport slave(input St, Dividend, Divisor, output Quotient, Remainder, V, Done);
endinterface

// File: rtl/fraction_division.sv
// fraction_division: sequential restoring signed fraction divider, one quotient bit per clock
module fraction_division (
  input logic CLK,
  input logic Rst,
  fraction_division_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CHK, S2, S1, S0, FIX, DONE} state_t;
  state_t state, nxt;
  logic [6:0] dmag, p, sub, dmag_in;
  logic [3:0] smag, smag_in, quo, rem;
  logic [2:0] q;
  logic [1:0] sh;
  logic sq, sr, v, ovf, ge;
  assign dmag_in = bus.Dividend[6] ? 7'd0 - bus.Dividend : bus.Dividend;
  assign smag_in = bus.Divisor[3] ? 4'd0 - bus.Divisor : bus.Divisor;
  // a quotient magnitude of 8 or more cannot be represented, so it is flagged like divide-by-zero
  assign ovf = smag == 4'd0 || dmag >= {smag, 3'b000};
  assign sh = state == S2 ? 2'd2 : state == S1 ? 2'd1 : 2'd0;
  assign sub = {3'b000, smag} << sh;
  assign ge = p >= sub;
  assign bus.Quotient = quo;
  assign bus.Remainder = rem;
  assign bus.V = v;
  assign bus.Done = state == DONE;
  always_ff @(posedge CLK)
    state <= Rst ? IDLE : nxt;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE: nxt = bus.St ? CHK : IDLE;
      CHK: nxt = ovf ? DONE : S2;
      S2: nxt = S1;
      S1: nxt = S0;
      S0: nxt = FIX;
      FIX: nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (Rst) begin
      dmag <= '0;
      smag <= '0;
      sq <= 1'b0;
      sr <= 1'b0;
      p <= '0;
      q <= '0;
      quo <= '0;
      rem <= '0;
      v <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.St) begin
          dmag <= dmag_in;
          smag <= smag_in;
          sq <= bus.Dividend[6] ^ bus.Divisor[3];
          sr <= bus.Dividend[6];
          p <= dmag_in;
          q <= '0;
        end
        CHK: begin
          v <= ovf;
          if (ovf) begin
            quo <= '0;
            rem <= '0;
          end
        end
        S2, S1, S0: begin
          if (ge) p <= p - sub;
          q <= {q[1:0], ge};
        end
        FIX: begin
          quo <= sq ? 4'd0 - {1'b0, q} : {1'b0, q};
          rem <= sr ? 4'd0 - p[3:0] : p[3:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fraction_division.sv
// tb_fraction_division: directed and exhaustive checks of the fraction divider
module tb_fraction_division;
  logic CLK = 1'b0;
  logic Rst = 1'b1;
  int errors = 0;
  int checks = 0;
  fraction_division_if bus();
  fraction_division dut (.CLK(CLK), .Rst(Rst), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic start(input int a, input int b);
    @(negedge CLK);
    bus.St = 1'b1;
    bus.Dividend = 7'(a);
    bus.Divisor = 4'(b);
    @(posedge CLK);
    @(negedge CLK);
    bus.St = 1'b0;
    bus.Dividend = ~7'(a);
    bus.Divisor = ~4'(b);
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.Done && lat < 20) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
  endtask
  task automatic expect_div(input string tag, input int a, input int b, input int eq, input int er, input int ev, input int el);
    int lat;
    start(a, b);
    wait_done(lat);
    chk({tag, ".lat"}, lat, el);
    chk({tag, ".q"}, int'(bus.Quotient), eq & 15);
    chk({tag, ".r"}, int'(bus.Remainder), er & 15);
    chk({tag, ".v"}, int'(bus.V), ev);
  endtask
  initial begin
    int lat;
    int seen;
    bus.St = 1'b0;
    bus.Dividend = '0;
    bus.Divisor = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst.q", int'(bus.Quotient), 0);
    chk("rst.r", int'(bus.Remainder), 0);
    chk("rst.v", int'(bus.V), 0);
    chk("rst.done", int'(bus.Done), 0);
    Rst = 1'b0;
    expect_div("exact", 24, 4, 6, 0, 0, 5);
    expect_div("negdv", -25, 4, -6, -1, 0, 5);
    expect_div("mix", 20, -3, -6, 2, 0, 5);
    expect_div("ext", 63, -8, -7, 7, 0, 5);
    expect_div("ovf", 32, 4, 0, 0, 1, 1);
    expect_div("dz", 5, 0, 0, 0, 1, 1);
    expect_div("m64", -64, -8, 0, 0, 1, 1);
    expect_div("pre_rst", 63, -8, -7, 7, 0, 5);
    start(24, 4);
    @(posedge CLK);
    @(posedge CLK);
    Rst = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Rst = 1'b0;
    chk("abort.done", int'(bus.Done), 0);
    chk("abort.q", int'(bus.Quotient), 0);
    chk("abort.r", int'(bus.Remainder), 0);
    chk("abort.v", int'(bus.V), 0);
    seen = 0;
    repeat (8) begin
      @(negedge CLK);
      seen += int'(bus.Done);
    end
    chk("abort.nodone", seen, 0);
    start(20, -3);
    @(negedge CLK);
    bus.St = 1'b1;
    bus.Dividend = 7'd32;
    bus.Divisor = 4'd4;
    @(negedge CLK);
    bus.St = 1'b0;
    wait_done(lat);
    chk("busy.lat", lat, 3);
    chk("busy.q", int'(bus.Quotient), 4'b1010);
    chk("busy.r", int'(bus.Remainder), 4'b0010);
    chk("busy.v", int'(bus.V), 0);
    @(negedge CLK);
    chk("busy.idle", int'(bus.Done), 0);
    for (int a = -64; a < 64; a++)
      for (int b = -8; b < 8; b++) begin
        int ma, mb, eq, er, ev;
        ma = a < 0 ? -a : a;
        mb = b < 0 ? -b : b;
        ev = (b == 0 || ma >= 8 * mb) ? 1 : 0;
        eq = ev ? 0 : a / b;
        er = ev ? 0 : a - eq * b;
        expect_div($sformatf("all(%0d,%0d)", a, b), a, b, eq, er, ev, ev ? 1 : 5);
      end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
